// File: rtl/gps_pkg.sv
// Shared definitions for the GPS date path: UART receiver state encoding,
// default frame/line parameters and a debug helper for state names.
package gps_pkg;

  localparam int unsigned S_Size = 3;

  typedef enum logic [S_Size-1:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } uart_state_e;

  localparam int unsigned DefaultB       = 8;
  localparam int unsigned DefaultClockHz = 100_000_000;
  localparam int unsigned DefaultBaud    = 9600;

  // Five ASCII characters, space padded, for waveform/debug annotation.
  function automatic logic [39:0] state_name(input uart_state_e s);
    logic [39:0] name;
    case (s)
      S_IDLE:  name = "IDLE ";
      S_START: name = "START";
      S_DATA:  name = "DATA ";
      S_STOP:  name = "STOP ";
      S_WAIT:  name = "WAIT ";
      default: name = "?????";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen to match the input's idle level so no false edge appears at reset.
module bit_synchronizer #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1_q, stage1_d;
  logic stage2_q, stage2_d;

  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 UART receiver feeding the GPZDA parser: one-cycle load strobe per good
// byte, one-cycle frame_error strobe per bad stop bit (byte discarded).
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int unsigned B       = DefaultB,
  parameter int unsigned ClockHz = DefaultClockHz,
  parameter int unsigned Baud    = DefaultBaud
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rx,
  output logic         load,
  output logic [B-1:0] data,
  output logic         frame_error,
  output logic         busy
);

  localparam int unsigned Div  = ClockHz / Baud;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CW   = $clog2(Div);
  localparam int unsigned BW   = (B > 1) ? $clog2(B) : 1;

  localparam logic [CW-1:0] HalfM1  = CW'(Half - 1);
  localparam logic [CW-1:0] DivM1   = CW'(Div - 1);
  localparam logic [BW-1:0] LastBit = BW'(B - 1);

  generate
    if (Div < 4) begin : g_div_check
      $error("gps_uart_rx: ClockHz/Baud must be at least 4");
    end
    if (B < 2) begin : g_b_check
      $error("gps_uart_rx: B must be at least 2");
    end
  endgenerate

  logic rx_s;

  bit_synchronizer #(
    .ResetValue(1'b1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [B-1:0]  shift_q, shift_d;
  logic [B-1:0]  data_q, data_d;
  logic          load_q, load_d;
  logic          frame_error_q, frame_error_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q + 1'b1;
    bit_d         = bit_q;
    shift_d       = shift_q;
    data_d        = data_q;
    load_d        = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (count_q == HalfM1) begin
          count_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (count_q == DivM1) begin
          count_d = '0;
          shift_d = {rx_s, shift_q[B-1:1]};
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        // Returning to Idle at mid stop bit leaves half a bit to catch the
        // next start edge of a back-to-back frame.
        if (count_q == DivM1) begin
          count_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            load_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        count_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      load_q        <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      load_q        <= load_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign load        = load_q;
  assign data        = data_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed bench for gps_uart_rx at Div=16, Half=8 (ClockHz=16, Baud=1).
module tb_gps_uart_rx;

  localparam int unsigned B       = 8;
  localparam int unsigned ClockHz = 16;
  localparam int unsigned Baud    = 1;
  localparam int unsigned BitT    = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rx    = 1'b1;
  logic         load;
  logic [B-1:0] data;
  logic         frame_error;
  logic         busy;

  gps_uart_rx #(
    .B      (B),
    .ClockHz(ClockHz),
    .Baud   (Baud)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .load       (load),
    .data       (data),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] loads[$];
  int         fe_count     = 0;
  int         last_load_cy = 0;
  int         viol         = 0;
  logic       prev_load    = 1'b0;
  logic       prev_fe      = 1'b0;
  logic [7:0] prev_data    = 8'h00;

  // Output monitor: records every byte strobe and protocol violations.
  always @(negedge clock) begin
    if (!reset) begin
      if (load) begin
        loads.push_back(data);
        last_load_cy = cyc;
      end
      if (frame_error) fe_count++;
      if (load && frame_error) viol++;
      if (load && prev_load) viol++;
      if (frame_error && prev_fe) viol++;
      if (!load && data !== prev_data) viol++;
    end
    prev_load = load;
    prev_fe   = frame_error;
    prev_data = data;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int frame_start_cy = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    frame_start_cy = cyc;
    wait_cycles(BitT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BitT);
    end
    rx = stop_bit;
    wait_cycles(BitT);
  endtask

  int         base;
  int         f0;
  int         lat;
  logic [7:0] zda[6];

  initial begin
    zda[0] = 8'h24; zda[1] = 8'h47; zda[2] = 8'h50;
    zda[3] = 8'h5A; zda[4] = 8'h44; zda[5] = 8'h41;

    // Reset values
    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(3);
    check("reset_load", 32'(load), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_cycles(10);

    // Single clean '$' frame with latency check
    base = loads.size();
    f0   = fe_count;
    send_frame(8'h24, 1'b1);
    lat = last_load_cy - frame_start_cy;
    wait_cycles(20);
    check("dollar_count", 32'(loads.size()), 32'(base + 1));
    if (loads.size() > base) check("dollar_data", 32'(loads[base]), 32'h24);
    check("dollar_no_fe", 32'(fe_count), 32'(f0));
    check("dollar_latency", 32'(lat >= 154 && lat <= 156), 32'd1);

    // "$GPZDA" back-to-back, no idle gap
    base = loads.size();
    for (int i = 0; i < 6; i++) send_frame(zda[i], 1'b1);
    wait_cycles(20);
    check("zda_count", 32'(loads.size()), 32'(base + 6));
    for (int i = 0; i < 6; i++)
      if (loads.size() > base + i) check("zda_byte", 32'(loads[base+i]), 32'(zda[i]));

    // 3-cycle glitch is rejected
    base = loads.size();
    f0   = fe_count;
    rx   = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(12);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_no_load", 32'(loads.size()), 32'(base));
    check("glitch_no_fe", 32'(fe_count), 32'(f0));
    wait_cycles(10);

    // Bad stop bit followed by a held-low break
    base = loads.size();
    f0   = fe_count;
    send_frame(8'h55, 1'b0);
    wait_cycles(40);
    check("break_busy_held", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cycles(6);
    check("break_busy_released", 32'(busy), 32'd0);
    wait_cycles(20);
    check("break_busy_stays_idle", 32'(busy), 32'd0);
    check("break_fe_once", 32'(fe_count), 32'(f0 + 1));
    check("break_no_load", 32'(loads.size()), 32'(base));
    check("break_data_kept", 32'(data), 32'h41);

    // All-zero and all-one data patterns
    base = loads.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cycles(20);
    check("bounds_count", 32'(loads.size()), 32'(base + 2));
    if (loads.size() > base)     check("bounds_00", 32'(loads[base]), 32'h00);
    if (loads.size() > base + 1) check("bounds_ff", 32'(loads[base+1]), 32'hFF);

    // Reset after the 4th data bit of 0xA5, then a clean 0x31
    base = loads.size();
    f0   = fe_count;
    rx   = 1'b0;
    wait_cycles(BitT);
    begin
      logic [7:0] partial;
      partial = 8'hA5;
      for (int i = 0; i < 4; i++) begin
        rx = partial[i];
        wait_cycles(BitT);
      end
    end
    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(2);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_load", 32'(load), 32'd0);
    reset = 1'b0;
    wait_cycles(20);
    check("midreset_no_output", 32'(loads.size()), 32'(base));
    send_frame(8'h31, 1'b1);
    wait_cycles(20);
    check("after_reset_count", 32'(loads.size()), 32'(base + 1));
    if (loads.size() > base) check("after_reset_data", 32'(loads[base]), 32'h31);
    check("after_reset_no_fe", 32'(fe_count), 32'(f0));

    check("strobe_protocol_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
